// File: rtl/muldiv_iter_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One shift-add or restoring-divide step per clock, then one sign-fix cycle.
module muldiv_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               sign_q;
  logic               sign_r;
  logic               div_zero;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc;

  logic               accept;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_wide(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Request qualification and operand magnitudes for signed ops
  always_comb begin
    accept = ready & req_valid & ~flush;
    sign_a = ~req_op[0] & req_a[WIDTH-1];
    sign_b = ~req_op[0] & req_b[WIDTH-1];
    if (sign_a) begin
      mag_a = negate(req_a);
    end else begin
      mag_a = req_a;
    end
    if (sign_b) begin
      mag_b = negate(req_b);
    end else begin
      mag_b = req_b;
    end
  end

  // One iteration step: acc holds {product hi, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_add   = acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}};
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + mul_add;
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_trial = div_shift - {1'b0, operand};
    if (is_div) begin
      if (!div_trial[WIDTH]) begin
        acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction; a zero divisor leaves |a| in the remainder, so re-signing restores req_a
  always_comb begin
    prod_fix = sign_q ? negate_wide(acc) : acc;
    if (is_div) begin
      fix_hi = sign_r ? negate(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
      if (div_zero) begin
        fix_lo = {WIDTH{1'b1}};
      end else begin
        fix_lo = sign_q ? negate(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
      end
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  // Control FSM, datapath registers and HI/LO
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= {CNT_W{1'b0}};
      is_div   <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      operand  <= {WIDTH{1'b0}};
      acc      <= {(2*WIDTH){1'b0}};
      HI       <= {WIDTH{1'b0}};
      LO       <= {WIDTH{1'b0}};
      done     <= 1'b0;
      ready    <= 1'b1;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) HI <= wr_data;
          if (lo_we) LO <= wr_data;
          if (accept) begin
            state    <= CALC;
            ready    <= 1'b0;
            busy     <= 1'b1;
            cnt      <= {CNT_W{1'b0}};
            is_div   <= req_op[1];
            sign_q   <= sign_a ^ sign_b;
            sign_r   <= sign_a;
            div_zero <= req_op[1] & (req_b == {WIDTH{1'b0}});
            operand  <= req_op[1] ? mag_b : mag_a;
            acc      <= {{WIDTH{1'b0}}, (req_op[1] ? mag_a : mag_b)};
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            acc <= acc_step;
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          if (!flush) begin
            HI   <= fix_hi;
            LO   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Self-checking bench for muldiv_iter_unit: transaction-level HI/LO model
// compared every cycle, plus directed vectors with hand-computed results.
module tb_muldiv_iter_unit;
  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         req_valid = 1'b0;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         flush = 1'b0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         ready, busy, done;
  logic [W-1:0] HI, LO;

  int n_checks = 0;
  int n_fail = 0;
  int n_model_fail = 0;
  bit checking = 1'b0;

  muldiv_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush), .hi_we(hi_we), .lo_we(lo_we),
    .wr_data(wr_data), .ready(ready), .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  // Architectural result of one operation, returned as {HI, LO}
  function automatic logic [63:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
    case (op)
      2'b00: begin sq = sa * sb; return sq; end
      2'b01: begin uq = ua * ub; return uq; end
      2'b10: begin sq = sa / sb; sr = sa % sb; return {sr[31:0], sq[31:0]}; end
      default: begin uq = ua / ub; ur = ua % ub; return {ur[31:0], uq[31:0]}; end
    endcase
  endfunction

  // Model state: cycles left until the result lands (0 = idle)
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;

  always @(posedge Clk) begin
    if (Reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (hi_we) m_hi <= wr_data;
        if (lo_we) m_lo <= wr_data;
        if (req_valid && !flush) begin
          m_pend <= model_res(req_op, req_a, req_b);
          m_left <= W + 1;
        end
      end else if (flush) begin
        m_left <= 0;
      end else if (m_left == 1) begin
        m_hi   <= m_pend[63:32];
        m_lo   <= m_pend[31:0];
        m_done <= 1'b1;
        m_left <= 0;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge Clk) begin
    if (checking) begin
      n_checks++;
      if ({ready, busy, done, HI, LO} !== {m_left == 0, m_left != 0, m_done, m_hi, m_lo}) begin
        n_fail++;
        if (n_model_fail < 10)
          $display("FAIL model_cmp t=%0t: got rdy=%b bsy=%b done=%b HI=%h LO=%h, expected rdy=%b bsy=%b done=%b HI=%h LO=%h",
                   $time, ready, busy, done, HI, LO, m_left == 0, m_left != 0, m_done, m_hi, m_lo);
        n_model_fail++;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one request; returns at the first negedge after the accepting edge
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int j;
    j = 0;
    while (!ready && j < 100) begin
      @(negedge Clk);
      j++;
    end
    check("issue_ready", ready, 1);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(negedge Clk);
    req_valid = 1'b0;
    req_op = 2'($urandom);
    req_a = $urandom;
    req_b = $urandom;
  endtask

  task automatic run_check(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    int j, nbusy;
    issue(op, a, b);
    j = 0;
    nbusy = 0;
    while (!done && j < 40) begin
      if (busy) nbusy++;
      @(negedge Clk);
      j++;
    end
    check({name, "_latency"}, j, 33);
    check({name, "_busy_cycles"}, nbusy, 33);
    check({name, "_ready_at_done"}, ready, 1);
    check({name, "_hi"}, HI, exp_hi);
    check({name, "_lo"}, LO, exp_lo);
    @(negedge Clk);
    check({name, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    repeat (2) @(negedge Clk);
    checking = 1'b1;
    check("reset_hi", HI, 0);
    check("reset_lo", LO, 0);
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    Reset = 1'b0;
    @(negedge Clk);

    run_check("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_check("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_check("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_check("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_check("divu_by0", 2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF);
    run_check("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_check("div_neg_by0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_check("div_7_neg2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_check("mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
    run_check("mult_min_x2", 2'b00, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'd0);
    run_check("multu_min_x2", 2'b01, 32'h8000_0000, 32'd2, 32'd1, 32'd0);
    run_check("mult_shift4", 2'b00, 32'h1234_5678, 32'h10, 32'd1, 32'h2345_6780);

    // Moves and request in the same idle cycle; moves land first, result overwrites
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd3; req_b = 32'd5;
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h5555;
    @(negedge Clk);
    req_valid = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("mt_both_hi", HI, 32'h5555);
    check("mt_both_lo", LO, 32'h5555);
    check("mt_req_busy", busy, 1);
    repeat (3) @(negedge Clk);
    hi_we = 1'b1; wr_data = 32'hDEAD;
    @(negedge Clk);
    hi_we = 1'b0;
    check("mt_ignored_busy", HI, 32'h5555);
    nd = 0;
    while (!done && nd < 40) begin @(negedge Clk); nd++; end
    check("mt_req_hi", HI, 32'd0);
    check("mt_req_lo", LO, 32'd15);

    // Flush in idle blocks acceptance
    @(negedge Clk);
    req_valid = 1'b1; flush = 1'b1; req_op = 2'b00; req_a = 32'd9; req_b = 32'd9;
    @(negedge Clk);
    req_valid = 1'b0; flush = 1'b0;
    check("idle_flush_ready", ready, 1);

    // Flush during the fix cycle: no write, no done
    issue(2'b01, 32'd6, 32'd7);
    repeat (32) @(negedge Clk);
    check("fix_still_busy", busy, 1);
    flush = 1'b1;
    @(negedge Clk);
    flush = 1'b0;
    check("fix_flush_done", done, 0);
    check("fix_flush_ready", ready, 1);
    check("fix_flush_hi", HI, 32'd0);
    check("fix_flush_lo", LO, 32'd15);

    // MTHI preload, ignored second request, flush mid-calc
    hi_we = 1'b1; wr_data = 32'hAAAA;
    @(negedge Clk);
    hi_we = 1'b0;
    check("mthi", HI, 32'hAAAA);
    issue(2'b00, 32'h1234, 32'h5678);
    repeat (5) @(negedge Clk);
    req_valid = 1'b1; req_op = 2'b11; req_a = 32'd100; req_b = 32'd7;
    @(negedge Clk);
    req_valid = 1'b0;
    check("second_req_busy", busy, 1);
    repeat (4) @(negedge Clk);
    flush = 1'b1;
    @(negedge Clk);
    flush = 1'b0;
    check("calc_flush_ready", ready, 1);
    check("calc_flush_done", done, 0);
    check("calc_flush_hi", HI, 32'hAAAA);
    check("calc_flush_lo", LO, 32'd15);
    nd = 0;
    repeat (40) begin
      @(negedge Clk);
      if (done) nd++;
    end
    check("calc_flush_no_done", nd, 0);

    // Reset mid-divide, then a fresh request
    issue(2'b11, 32'd1000, 32'd3);
    repeat (20) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("midreset_hi", HI, 0);
    check("midreset_lo", LO, 0);
    check("midreset_ready", ready, 1);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    run_check("divu_after_reset", 2'b11, 32'd1000, 32'd3, 32'd1, 32'd333);

    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
